// File: rtl/credit_vc_tx_arb.sv
// Purpose : credit-based output-port transmitter; arbitrates VC_W flit streams onto one link.
// Latency : 1 cycle from accept (i_v & ~i_b) to o_d/o_vc_target.
// Backpr. : i_b[v] is low only for the single granted VC; no grant without a downstream credit.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_v/i_d/i_b   per-VC flit valid / flit {last, addr, data} / backpressure
//   o_d           registered output flit
//   o_vc_target   registered one-hot VC of o_d (all-zero = idle)
//   credit_gnt    per-VC credit return from downstream
//   o_credits     registered per-VC credit counters
//   o_credit_err  sticky flag: credit returned into a full counter
module credit_vc_tx_arb #(
  parameter int A_W           = 8,
  parameter int D_W           = 16,
  parameter int VC_W          = 2,
  parameter int VC_FIFO_DEPTH = 4,
  parameter int FAIR_VC_ARB   = 0,
  parameter int PKT_LOCK      = 0,
  localparam int FW           = A_W + D_W + 1,
  localparam int CW           = $clog2(VC_FIFO_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [VC_W-1:0]          i_v,
  input  logic [VC_W-1:0][FW-1:0]  i_d,
  output logic [VC_W-1:0]          i_b,
  output logic [FW-1:0]            o_d,
  output logic [VC_W-1:0]          o_vc_target,
  input  logic [VC_W-1:0]          credit_gnt,
  output logic [VC_W-1:0][CW-1:0]  o_credits,
  output logic                     o_credit_err
);

  localparam int PW = (VC_W > 1) ? $clog2(VC_W) : 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(VC_FIFO_DEPTH - 1);

  // run_q holds off arbitration until the first edge after reset release,
  // so nothing is accepted or emitted on that edge.
  logic                     run_q;
  logic [VC_W-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]            ptr_q, ptr_d;
  logic                     lock_q, lock_d;
  logic [PW-1:0]            lock_vc_q, lock_vc_d;
  logic [FW-1:0]            o_d_q, o_d_d;
  logic [VC_W-1:0]          vc_q, vc_d;
  logic                     err_q, err_d;

  logic [VC_W-1:0]          elig;
  logic [VC_W-1:0]          rot;
  logic [VC_W-1:0]          grant;
  logic                     hit;
  logic [PW-1:0]            off;
  logic [PW:0]              sum;
  logic [PW:0]              nxt;
  logic [PW-1:0]            gidx;
  logic                     acc;

  // Eligibility: valid, at least one credit, and not shut out by a held lock.
  always_comb begin
    elig = '0;
    for (int v = 0; v < VC_W; v++) begin
      elig[v] = run_q & i_v[v] & (cnt_q[v] != '0) &
                (~lock_q | (lock_vc_q == PW'(v)));
    end
  end

  // Arbitration: rotate the request vector so the search always starts at
  // bit 0, pick the first hit, then rotate the offset back into a VC index.
  always_comb begin
    if (FAIR_VC_ARB != 0 && VC_W > 1) begin
      rot = VC_W'({elig, elig} >> ptr_q);
    end else begin
      rot = elig;
    end
    hit = 1'b0;
    off = '0;
    for (int k = 0; k < VC_W; k++) begin
      if (!hit && rot[k]) begin
        hit = 1'b1;
        off = PW'(k);
      end
    end
    if (FAIR_VC_ARB != 0) begin
      sum = {1'b0, ptr_q} + {1'b0, off};
    end else begin
      sum = {1'b0, off};
    end
    if (sum >= (PW+1)'(VC_W)) begin
      sum = sum - (PW+1)'(VC_W);
    end
    gidx  = sum[PW-1:0];
    grant = hit ? (VC_W'(1) << gidx) : '0;
  end

  assign acc = |grant;

  always_comb begin
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    lock_vc_d = lock_vc_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    vc_d      = grant;

    // One-hot grant selects the flit with an AND-OR mux; zero when idle.
    o_d_d = '0;
    for (int v = 0; v < VC_W; v++) begin
      o_d_d = o_d_d | (i_d[v] & {FW{grant[v]}});
    end

    nxt = {1'b0, gidx} + (PW+1)'(1);
    if (nxt >= (PW+1)'(VC_W)) begin
      nxt = '0;
    end
    if (acc && FAIR_VC_ARB != 0) begin
      ptr_d = nxt[PW-1:0];
    end

    // A non-last flit locks (or keeps) the link for its VC; a last flit frees it.
    if (PKT_LOCK != 0 && acc) begin
      lock_d    = ~o_d_d[FW-1];
      lock_vc_d = gidx;
    end

    // Send and return in the same cycle cancel; a return into a full counter
    // saturates and raises the sticky error.
    for (int v = 0; v < VC_W; v++) begin
      if (credit_gnt[v] && !grant[v]) begin
        if (cnt_q[v] == CRED_MAX) begin
          err_d = 1'b1;
        end else begin
          cnt_d[v] = cnt_q[v] + CW'(1);
        end
      end else if (grant[v] && !credit_gnt[v]) begin
        cnt_d[v] = cnt_q[v] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= 1'b0;
      cnt_q     <= {VC_W{CRED_MAX}};
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_vc_q <= '0;
      o_d_q     <= '0;
      vc_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      run_q     <= 1'b1;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      lock_vc_q <= lock_vc_d;
      o_d_q     <= o_d_d;
      vc_q      <= vc_d;
      err_q     <= err_d;
    end
  end

  assign i_b          = ~grant;
  assign o_d          = o_d_q;
  assign o_vc_target  = vc_q;
  assign o_credits    = cnt_q;
  assign o_credit_err = err_q;

endmodule

// File: tb/tb_credit_vc_tx_arb.sv
// Purpose : self-checking bench for credit_vc_tx_arb (round-robin+lock and static instances).
// Latency : expected flits queued at stimulus time, compared when the DUT emits them.
// Backpr. : sources advance only on accept (valid & ~i_b).
module tb_credit_vc_tx_arb;

  localparam int A_W = 8;
  localparam int D_W = 16;
  localparam int FW  = A_W + D_W + 1;

  typedef struct packed {
    logic [3:0]    vc;
    logic [FW-1:0] dat;
  } exp_t;

  logic clk;
  logic rst_n;

  // Instance A: round-robin with packet lock. Instance B: static priority, no lock.
  logic [3:0]          v_a, b_a, g_a, gm_a, vt_a, acc_a;
  logic [3:0][FW-1:0]  d_a;
  logic [FW-1:0]       od_a;
  logic [3:0][1:0]     cr_a;
  logic                err_a, follow_a;

  logic [3:0]          v_b, b_b, g_b, gm_b, vt_b, acc_b;
  logic [3:0][FW-1:0]  d_b;
  logic [FW-1:0]       od_b;
  logic [3:0][1:0]     cr_b;
  logic                err_b, follow_b;

  // Downstream model: either return a credit for every flit sent, or manual pulses.
  assign g_a = follow_a ? (v_a & ~b_a) : gm_a;
  assign g_b = follow_b ? (v_b & ~b_b) : gm_b;

  credit_vc_tx_arb #(
    .A_W(A_W), .D_W(D_W), .VC_W(4), .VC_FIFO_DEPTH(4), .FAIR_VC_ARB(1), .PKT_LOCK(1)
  ) u_rr (
    .clk(clk), .rst_n(rst_n), .i_v(v_a), .i_d(d_a), .i_b(b_a), .o_d(od_a),
    .o_vc_target(vt_a), .credit_gnt(g_a), .o_credits(cr_a), .o_credit_err(err_a)
  );

  credit_vc_tx_arb #(
    .A_W(A_W), .D_W(D_W), .VC_W(4), .VC_FIFO_DEPTH(4), .FAIR_VC_ARB(0), .PKT_LOCK(0)
  ) u_st (
    .clk(clk), .rst_n(rst_n), .i_v(v_b), .i_d(d_b), .i_b(b_b), .o_d(od_b),
    .o_vc_target(vt_b), .credit_gnt(g_b), .o_credits(cr_b), .o_credit_err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [FW-1:0] src_a [4][$];
  logic [FW-1:0] src_b [4][$];
  exp_t          q_a[$];
  exp_t          q_b[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] flit(input logic last, input int vc, input int seq);
    return {last, A_W'(vc), D_W'(seq)};
  endfunction

  function automatic exp_t mk_exp(input int vc, input logic [FW-1:0] dat);
    exp_t e;
    e.vc  = 4'b0001 << vc;
    e.dat = dat;
    return e;
  endfunction

  // Present queue heads, record which VCs get accepted at the next edge,
  // then advance the sources. Manual credit pulses last exactly one cycle.
  task automatic cyc();
    for (int v = 0; v < 4; v++) begin
      v_a[v] = (src_a[v].size() != 0);
      d_a[v] = v_a[v] ? src_a[v][0] : '0;
      v_b[v] = (src_b[v].size() != 0);
      d_b[v] = v_b[v] ? src_b[v][0] : '0;
    end
    #1;
    acc_a = v_a & ~b_a;
    acc_b = v_b & ~b_b;
    @(posedge clk);
    #1;
    for (int v = 0; v < 4; v++) begin
      if (acc_a[v]) void'(src_a[v].pop_front());
      if (acc_b[v]) void'(src_b[v].pop_front());
    end
    gm_a = '0;
    gm_b = '0;
  endtask

  task automatic clear_src();
    for (int v = 0; v < 4; v++) begin
      src_a[v].delete();
      src_b[v].delete();
    end
  endtask

  // Output monitors: every emitted flit must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && vt_a != 4'b0) begin
      if (q_a.size() == 0) begin
        check_eq("a_unexpected_flit", {vt_a, od_a}, '0);
      end else begin
        e = q_a.pop_front();
        check_eq("a_vc", vt_a, e.vc);
        check_eq("a_dat", od_a, e.dat);
      end
    end
    if (rst_n && vt_b != 4'b0) begin
      if (q_b.size() == 0) begin
        check_eq("b_unexpected_flit", {vt_b, od_b}, '0);
      end else begin
        e = q_b.pop_front();
        check_eq("b_vc", vt_b, e.vc);
        check_eq("b_dat", od_b, e.dat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] f;
    rst_n = 1'b0;
    follow_a = 1'b0; follow_b = 1'b0;
    gm_a = '0; gm_b = '0;
    acc_a = '0; acc_b = '0;
    v_a = 4'hF; v_b = 4'hF;
    d_a = '0; d_b = '0;

    // Reset state, with all valids high to show i_b held high.
    #12;
    check_eq("rst_vt", vt_a, 4'h0);
    check_eq("rst_od", od_a, '0);
    check_eq("rst_credits", cr_a, 8'hFF);
    check_eq("rst_err", err_a, 1'b0);
    check_eq("rst_ib_a", b_a, 4'hF);
    check_eq("rst_ib_b", b_b, 4'hF);
    v_a = '0; v_b = '0;
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Credit exhaustion on VC0: exactly three single-flit packets back to back.
    for (int i = 0; i < 4; i++) src_a[0].push_back(flit(1'b1, 0, 16'h0100 + i));
    for (int i = 0; i < 3; i++) q_a.push_back(mk_exp(0, flit(1'b1, 0, 16'h0100 + i)));
    for (int k = 1; k <= 5; k++) begin
      cyc();
      check_eq($sformatf("exh_vt_c%0d", k), vt_a, (k <= 3) ? 4'b0001 : 4'b0000);
    end
    check_eq("exh_ib0", b_a[0], 1'b1);
    check_eq("exh_credits", cr_a, 8'hFC);

    // A returned credit is usable the following cycle, never the same one.
    q_a.push_back(mk_exp(0, flit(1'b1, 0, 16'h0103)));
    gm_a = 4'b0001;
    cyc();
    check_eq("crd_no_same_cycle", acc_a[0], 1'b0);
    check_eq("crd_cnt_up", cr_a[0], 2'd1);
    check_eq("crd_vt_idle", vt_a, 4'b0000);
    cyc();
    check_eq("crd_accept_next", acc_a[0], 1'b1);
    check_eq("crd_vt_out", vt_a, 4'b0001);
    check_eq("crd_cnt_zero", cr_a[0], 2'd0);
    for (int i = 0; i < 3; i++) begin
      gm_a = 4'b0001;
      cyc();
    end
    check_eq("crd_restored", cr_a, 8'hFF);
    check_eq("crd_no_err", err_a, 1'b0);

    // Round-robin on A (pointer now at VC1) and static priority on B, together.
    follow_a = 1'b1;
    follow_b = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 4; j++) begin
        int vc;
        vc = (1 + j) % 4;
        f = flit(1'b1, vc, 16'h0200 + r);
        src_a[vc].push_back(f);
        q_a.push_back(mk_exp(vc, f));
      end
    end
    for (int vc = 0; vc < 4; vc++) begin
      for (int i = 0; i < 3; i++) begin
        f = flit(1'b0, vc, 16'h0300 + i);
        src_b[vc].push_back(f);
        q_b.push_back(mk_exp(vc, f));
      end
    end
    for (int k = 0; k < 13; k++) cyc();
    check_eq("rr_drained", q_a.size(), 0);
    check_eq("st_drained", q_b.size(), 0);
    check_eq("rr_credits", cr_a, 8'hFF);
    check_eq("st_credits", cr_b, 8'hFF);
    follow_a = 1'b0;
    follow_b = 1'b0;

    // Simultaneous send and credit return on B, then saturation.
    f = flit(1'b1, 0, 16'h0400);
    src_b[0].push_back(f); q_b.push_back(mk_exp(0, f));
    cyc();
    check_eq("sg_cnt2", cr_b, 8'hFE);
    f = flit(1'b1, 0, 16'h0401);
    src_b[0].push_back(f); q_b.push_back(mk_exp(0, f));
    gm_b = 4'b0001;
    cyc();
    check_eq("sg_accepted", acc_b[0], 1'b1);
    check_eq("sg_cnt_hold", cr_b, 8'hFE);
    gm_b = 4'b0001;
    cyc();
    check_eq("sat_cnt3", cr_b, 8'hFF);
    check_eq("sat_no_err_yet", err_b, 1'b0);
    gm_b = 4'b0001;
    cyc();
    check_eq("sat_cnt_held", cr_b, 8'hFF);
    check_eq("sat_err_set", err_b, 1'b1);
    cyc();
    check_eq("sat_err_sticky", err_b, 1'b1);

    // Packet lock: VC1's three-flit packet goes out whole before VC0.
    follow_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f = flit(i == 2, 1, 16'h0500 + i);
      src_a[1].push_back(f); q_a.push_back(mk_exp(1, f));
    end
    for (int i = 0; i < 2; i++) begin
      f = flit(1'b1, 0, 16'h0510 + i);
      src_a[0].push_back(f); q_a.push_back(mk_exp(0, f));
    end
    for (int k = 0; k < 6; k++) cyc();
    check_eq("lock_drained", q_a.size(), 0);
    follow_a = 1'b0;

    // Credit starvation mid-packet: link idles and VC0 stays shut out.
    for (int i = 0; i < 3; i++) begin
      f = flit(1'b0, 1, 16'h0600 + i);
      src_a[1].push_back(f); q_a.push_back(mk_exp(1, f));
    end
    src_a[1].push_back(flit(1'b1, 1, 16'h0603));
    src_a[0].push_back(flit(1'b1, 0, 16'h0610));
    for (int k = 0; k < 3; k++) cyc();
    for (int k = 0; k < 3; k++) begin
      cyc();
      check_eq($sformatf("starve_idle_c%0d", k), vt_a, 4'b0000);
      check_eq($sformatf("starve_vc0_blocked_c%0d", k), b_a[0], 1'b1);
    end
    check_eq("starve_credits", cr_a, 8'hF3);
    q_a.push_back(mk_exp(1, flit(1'b1, 1, 16'h0603)));
    q_a.push_back(mk_exp(0, flit(1'b1, 0, 16'h0610)));
    gm_a = 4'b0010;
    cyc();
    check_eq("starve_gnt_not_same", acc_a, 4'b0000);
    cyc();
    check_eq("starve_last_out", vt_a, 4'b0010);
    cyc();
    check_eq("starve_vc0_after", vt_a, 4'b0001);
    cyc();
    check_eq("starve_credits_end", cr_a, 8'hF2);
    check_eq("starve_drained", q_a.size(), 0);

    // Asynchronous reset while VC2 holds the lock.
    for (int i = 0; i < 3; i++) src_a[2].push_back(flit(i == 2, 2, 16'h0700 + i));
    cyc();
    check_eq("arst_pre_vt", vt_a, 4'b0100);
    check_eq("arst_pre_od", od_a, flit(1'b0, 2, 16'h0700));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_vt", vt_a, 4'b0000);
    check_eq("arst_od", od_a, '0);
    check_eq("arst_credits", cr_a, 8'hFF);
    check_eq("arst_err_a", err_a, 1'b0);
    check_eq("arst_err_b", err_b, 1'b0);
    check_eq("arst_ib", b_a, 4'hF);
    clear_src();
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // After release: no accept on the first edge, lock gone, pointer back at VC0.
    for (int j = 0; j < 3; j++) begin
      int vc;
      vc = (j == 2) ? 3 : j;
      f = flit(1'b1, vc, 16'h0800 + j);
      src_a[vc].push_back(f); q_a.push_back(mk_exp(vc, f));
    end
    cyc();
    check_eq("post_rst_no_accept", acc_a, 4'b0000);
    check_eq("post_rst_vt_idle", vt_a, 4'b0000);
    for (int k = 0; k < 4; k++) cyc();
    check_eq("post_rst_drained_a", q_a.size(), 0);
    check_eq("post_rst_drained_b", q_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
